// File: rtl/audio_gain_fifo_pkg.sv
// Shared types and the shift-and-saturate helper for the audio gain stage.
// sat_shift works on wide vectors so that one function covers every parameterisation.
package audio_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned GAIN_W_DEF = 8;
    localparam int unsigned UNITY_GAIN = 1 << (GAIN_W_DEF - 2);

    // Headroom for any product DATA_W+GAIN_W+1 up to SAT_W bits, results up to VAL_W bits.
    localparam int unsigned SAT_W = 128;
    localparam int unsigned VAL_W = 64;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] l;
        logic signed [DATA_W_DEF-1:0] r;
    } sample_t;

    typedef struct packed {
        logic [VAL_W-1:0] value;
        logic             clip;
    } sat_t;

    function automatic sat_t sat_shift(input logic signed [SAT_W-1:0] prod,
                                       input int unsigned shift,
                                       input int unsigned data_w);
        logic signed [SAT_W-1:0] sh;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t res;
        sh = prod >>> shift;
        for (int i = 0; i < int'(SAT_W); i++) begin
            hi[i] = (i < int'(data_w) - 1);
        end
        lo = ~hi;
        res.clip = 1'b1;
        if (sh > hi) begin
            res.value = hi[VAL_W-1:0];
        end else if (sh < lo) begin
            res.value = lo[VAL_W-1:0];
        end else begin
            res.value = sh[VAL_W-1:0];
            res.clip  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Show-ahead register-array FIFO holding packed stereo samples.
// DEPTH must be a power of two so the pointers wrap naturally.
module audio_sample_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LVL_W'(DEPTH));
        do_push  = push && !full;
        do_pop   = pop && !empty;
        pop_data = mem[rd_ptr_q];
        level    = level_q;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/audio_gain_fifo.sv
// Stereo gain stage: credit-gated input, soft-mute gain ramp, two-stage multiply/saturate
// pipeline with sticky clip flags, and a show-ahead output FIFO.
module audio_gain_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned GAIN_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RAMP_STEP = 1
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     audio_in_available,
    output logic                     read_audio_in,
    input  logic [DATA_W-1:0]        audio_in_L,
    input  logic [DATA_W-1:0]        audio_in_R,
    input  logic                     audio_out_allowed,
    output logic                     write_audio_out,
    output logic [DATA_W-1:0]        audio_out_L,
    output logic [DATA_W-1:0]        audio_out_R,
    input  logic [GAIN_W-1:0]        gain,
    input  logic                     mute,
    input  logic                     bypass,
    input  logic                     clip_clear,
    output logic                     clip_L,
    output logic                     clip_R,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned PW    = DATA_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << (GAIN_W - 2);
    localparam logic [GAIN_W:0]   STEP  = (GAIN_W + 1)'(RAMP_STEP);

    logic              s1_valid_q, s1_bypass_q, s2_valid_q;
    logic [DATA_W-1:0] s1_l_q, s1_r_q, s2_l_q, s2_r_q;
    logic [GAIN_W-1:0] s1_gain_q, cur_gain_q, cur_gain_d, target;
    logic              clip_l_q, clip_r_q;

    logic [LVL_W:0]          occupancy;
    logic                    fifo_empty, fifo_full;
    logic [2*DATA_W-1:0]     fifo_head;
    logic signed [PW-1:0]    ext_l, ext_r, ext_g, prod_l, prod_r;
    sat_t                    sat_l, sat_r;
    logic [DATA_W-1:0]       s2_l_d, s2_r_d;
    logic                    clip_l_set, clip_r_set;
    logic                    unused_bits;

    // Every accepted sample occupies either a pipeline stage or a FIFO slot.
    always_comb begin
        occupancy       = {1'b0, fifo_level} + (LVL_W + 1)'(s1_valid_q) +
                          (LVL_W + 1)'(s2_valid_q);
        read_audio_in   = !reset && audio_in_available && (occupancy < (LVL_W + 1)'(DEPTH));
        write_audio_out = !reset && audio_out_allowed && !fifo_empty;
        audio_out_L     = fifo_empty ? '0 : fifo_head[2*DATA_W-1:DATA_W];
        audio_out_R     = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
        clip_L          = clip_l_q;
        clip_R          = clip_r_q;
    end

    always_comb begin
        target     = mute ? '0 : gain;
        cur_gain_d = cur_gain_q;
        if (read_audio_in) begin
            if (cur_gain_q < target) begin
                cur_gain_d = ({1'b0, target - cur_gain_q} > STEP) ?
                             cur_gain_q + STEP[GAIN_W-1:0] : target;
            end else if (cur_gain_q > target) begin
                cur_gain_d = ({1'b0, cur_gain_q - target} > STEP) ?
                             cur_gain_q - STEP[GAIN_W-1:0] : target;
            end
        end
    end

    always_comb begin
        ext_l  = {{(GAIN_W + 1){s1_l_q[DATA_W-1]}}, s1_l_q};
        ext_r  = {{(GAIN_W + 1){s1_r_q[DATA_W-1]}}, s1_r_q};
        ext_g  = {{DATA_W{1'b0}}, 1'b0, s1_gain_q};
        prod_l = ext_l * ext_g;
        prod_r = ext_r * ext_g;
        sat_l  = sat_shift({{(SAT_W - PW){prod_l[PW-1]}}, prod_l}, GAIN_W - 2, DATA_W);
        sat_r  = sat_shift({{(SAT_W - PW){prod_r[PW-1]}}, prod_r}, GAIN_W - 2, DATA_W);
        s2_l_d = s1_bypass_q ? s1_l_q : sat_l.value[DATA_W-1:0];
        s2_r_d = s1_bypass_q ? s1_r_q : sat_r.value[DATA_W-1:0];
        clip_l_set = s1_valid_q && !s1_bypass_q && sat_l.clip;
        clip_r_set = s1_valid_q && !s1_bypass_q && sat_r.clip;
    end

    assign unused_bits = ^{sat_l.value[VAL_W-1:DATA_W], sat_r.value[VAL_W-1:DATA_W], fifo_full};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_bypass_q <= 1'b0;
            s1_l_q      <= '0;
            s1_r_q      <= '0;
            s1_gain_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_l_q      <= '0;
            s2_r_q      <= '0;
            cur_gain_q  <= UNITY;
            clip_l_q    <= 1'b0;
            clip_r_q    <= 1'b0;
        end else begin
            s1_valid_q <= read_audio_in;
            if (read_audio_in) begin
                s1_l_q      <= audio_in_L;
                s1_r_q      <= audio_in_R;
                s1_gain_q   <= cur_gain_q;
                s1_bypass_q <= bypass;
            end
            cur_gain_q <= cur_gain_d;
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_l_q <= s2_l_d;
                s2_r_q <= s2_r_d;
            end
            // A new clip outranks a simultaneous clear.
            clip_l_q <= clip_l_set | (clip_l_q & ~clip_clear);
            clip_r_q <= clip_r_set | (clip_r_q & ~clip_clear);
        end
    end

    audio_sample_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLOCK_50),
        .reset     (reset),
        .push      (s2_valid_q),
        .push_data ({s2_l_q, s2_r_q}),
        .pop       (write_audio_out),
        .pop_data  (fifo_head),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_audio_gain_fifo.sv
// Directed and randomised bench for audio_gain_fifo against an arithmetic sample model.
module tb_audio_gain_fifo;

    localparam int DEPTH = 4;
    localparam int STEP  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        avail = 1'b0;
    logic        allowed = 1'b0;
    logic [31:0] in_L = '0;
    logic [31:0] in_R = '0;
    logic [7:0]  gain = 8'd64;
    logic        mute = 1'b0;
    logic        bypass = 1'b0;
    logic        clip_clear = 1'b0;
    logic        read_audio_in, write_audio_out, clip_L, clip_R;
    logic [31:0] audio_out_L, audio_out_R;
    logic [2:0]  fifo_level;

    always #5 clk = ~clk;

    audio_gain_fifo #(
        .DATA_W    (32),
        .GAIN_W    (8),
        .DEPTH     (DEPTH),
        .RAMP_STEP (STEP)
    ) dut (
        .CLOCK_50           (clk),
        .reset              (reset),
        .audio_in_available (avail),
        .read_audio_in      (read_audio_in),
        .audio_in_L         (in_L),
        .audio_in_R         (in_R),
        .audio_out_allowed  (allowed),
        .write_audio_out    (write_audio_out),
        .audio_out_L        (audio_out_L),
        .audio_out_R        (audio_out_R),
        .gain               (gain),
        .mute               (mute),
        .bypass             (bypass),
        .clip_clear         (clip_clear),
        .clip_L             (clip_L),
        .clip_R             (clip_R),
        .fifo_level         (fifo_level)
    );

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mgain = 64;
    int   acc_total = 0;
    int   first_rd = -1;
    int   first_wr = -1;
    bit   exp_clip_l = 1'b0;
    bit   exp_clip_r = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // y = floor(x * g / 64), clamped to the signed 32-bit range.
    function automatic logic [31:0] model(input logic [31:0] x, input int g, input bit byp,
                                          output bit clip);
        longint p;
        clip = 1'b0;
        if (byp) return x;
        p = longint'($signed(x)) * longint'(g);
        p = p >>> 6;
        if (p > 64'sd2147483647) begin
            clip = 1'b1;
            return 32'h7FFFFFFF;
        end
        if (p < -64'sd2147483648) begin
            clip = 1'b1;
            return 32'h80000000;
        end
        return p[31:0];
    endfunction

    function automatic int ramp(input int g, input int t);
        if (g < t) return (g + STEP < t) ? g + STEP : t;
        return (g - STEP > t) ? g - STEP : t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] l, input logic [31:0] r, input int n);
        int start;
        int guard;
        in_L  = l;
        in_R  = r;
        avail = 1'b1;
        start = acc_total;
        guard = 0;
        while (acc_total - start < n && guard < 200) begin
            tick();
            guard++;
        end
        avail = 1'b0;
        check("send_accepted", acc_total - start, n);
    endtask

    task automatic drain();
        int guard;
        allowed = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 60) begin
            tick();
            guard++;
        end
        tick();
        tick();
        check("drain_left", q.size(), 0);
    endtask

    initial begin
        int base;
        int v;
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (reset) begin
                    check("read_in_reset", read_audio_in, 0);
                    check("write_in_reset", write_audio_out, 0);
                    q.delete();
                    mgain      = 64;
                    exp_clip_l = 1'b0;
                    exp_clip_r = 1'b0;
                    first_rd   = -1;
                    first_wr   = -1;
                end else begin
                    exp_t e;
                    bit   cl;
                    bit   cr;
                    int   cnt;
                    cnt = 0;
                    foreach (q[i]) if (q[i].c + 3 <= cyc) cnt++;
                    check("fifo_level", fifo_level, cnt);
                    check("write_audio_out", write_audio_out, allowed && cnt != 0);
                    check("read_audio_in", read_audio_in, avail && q.size() < DEPTH);
                    if (cnt == 0) begin
                        check("out_L_empty", audio_out_L, 0);
                        check("out_R_empty", audio_out_R, 0);
                    end
                    if (write_audio_out && cnt != 0) begin
                        check("out_L", audio_out_L, q[0].l);
                        check("out_R", audio_out_R, q[0].r);
                        void'(q.pop_front());
                        if (first_wr < 0) first_wr = cyc;
                    end
                    if (read_audio_in) begin
                        e.l = model(in_L, mgain, bypass, cl);
                        e.r = model(in_R, mgain, bypass, cr);
                        e.c = cyc;
                        q.push_back(e);
                        exp_clip_l = exp_clip_l | cl;
                        exp_clip_r = exp_clip_r | cr;
                        mgain = ramp(mgain, mute ? 0 : int'(gain));
                        acc_total++;
                        if (first_rd < 0) first_rd = cyc;
                    end
                end
            end
        join_none

        // Reset state
        tick();
        tick();
        check("rst_read", read_audio_in, 0);
        check("rst_write", write_audio_out, 0);
        check("rst_out_L", audio_out_L, 0);
        check("rst_out_R", audio_out_R, 0);
        check("rst_level", fifo_level, 0);
        check("rst_clip_L", clip_L, 0);
        check("rst_clip_R", clip_R, 0);
        reset   = 1'b0;
        allowed = 1'b1;

        // Unity gain and 3-cycle latency
        send(32'd1000, 32'hFFFFFC18, 1);
        drain();
        check("t1_latency", first_wr - first_rd, 3);

        // Saturation and sticky clip flags
        gain = 8'd128;
        send(32'd0, 32'd0, 4);
        send(32'h70000000, 32'h90000000, 1);
        drain();
        check("t2_clip_L", clip_L, exp_clip_l);
        check("t2_clip_R", clip_R, exp_clip_r);
        clip_clear = 1'b1;
        tick();
        clip_clear = 1'b0;
        exp_clip_l = 1'b0;
        exp_clip_r = 1'b0;
        check("t2_clear_L", clip_L, 0);
        check("t2_clear_R", clip_R, 0);

        // Soft mute ramp down and back up
        gain = 8'd64;
        send(32'd0, 32'd0, 4);
        mute = 1'b1;
        send(32'd6400, 32'd6400, 8);
        mute = 1'b0;
        send(32'd6400, 32'd6400, 6);
        drain();

        // Backpressure: credit limits acceptance to DEPTH
        allowed = 1'b0;
        base = acc_total;
        avail = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_L = 32'h1000 + i;
            in_R = 32'h2000 + i;
            tick();
        end
        check("t4_accepted", acc_total - base, DEPTH);
        check("t4_level", fifo_level, DEPTH);
        check("t4_read_low", read_audio_in, 0);
        allowed = 1'b1;
        for (int i = 0; i < 20 && acc_total - base < 6; i++) begin
            in_L = 32'h1100 + i;
            in_R = 32'h2100 + i;
            tick();
        end
        avail = 1'b0;
        check("t4_total", acc_total - base, 6);
        drain();

        // Bypass ignores gain
        bypass = 1'b1;
        gain   = 8'd0;
        send(32'hDEADBEEF, 32'h12345678, 1);
        drain();
        check("t5_clip_L", clip_L, 0);
        check("t5_clip_R", clip_R, 0);
        bypass = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            avail   = ($urandom_range(0, 3) != 0);
            allowed = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) gain = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) mute = ~mute;
            if ($urandom_range(0, 15) == 0) bypass = ~bypass;
            if ($urandom_range(0, 1) == 0) begin
                in_L = $urandom;
                in_R = $urandom;
            end else begin
                v = $urandom_range(0, 20000);
                in_L = v - 10000;
                v = $urandom_range(0, 20000);
                in_R = v - 10000;
            end
            tick();
        end
        avail  = 1'b0;
        mute   = 1'b0;
        bypass = 1'b0;
        drain();
        check("rand_clip_L", clip_L, exp_clip_l);
        check("rand_clip_R", clip_R, exp_clip_r);

        // Mid-stream reset flushes everything and restores unity gain
        gain    = 8'd64;
        allowed = 1'b0;
        send(32'd11, 32'd12, 1);
        send(32'd21, 32'd22, 1);
        send(32'd31, 32'd32, 1);
        for (int i = 0; i < 10 && fifo_level != 3; i++) tick();
        check("t6_level_before", fifo_level, 3);
        reset = 1'b1;
        tick();
        check("t6_level", fifo_level, 0);
        check("t6_write", write_audio_out, 0);
        check("t6_out_L", audio_out_L, 0);
        check("t6_out_R", audio_out_R, 0);
        check("t6_clip_L", clip_L, 0);
        reset   = 1'b0;
        gain    = 8'd200;
        allowed = 1'b1;
        send(32'd1000, 32'hFFFFFC18, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_gain_fifo.md
# audio_gain_fifo

Stereo sample-processing stage between the audio-codec input and output handshakes in `top`, replacing the fixed passthrough/mute path. It applies a per-sample signed gain with click-free soft-mute ramping and saturation, with a bypass mode. Processed samples go into an output FIFO, so `write_audio_out` is never asserted before its data is valid. Sample width, gain format, FIFO depth and ramp rate are parameters.

## Interface
- `DATA_W`, 32: sample width, signed two's complement.
- `GAIN_W`, 8: unsigned gain width, Q2.(GAIN_W-2); unity = 1<<(GAIN_W-2) = 64.
- `DEPTH`, 4: output FIFO depth in stereo samples, power of 2, ≥2.
- `RAMP_STEP`, 1: gain change per accepted sample while ramping.
- `CLOCK_50` in 1: sole clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `audio_in_available` in 1: codec has an input sample.
- `read_audio_in` out 1: sample consumed at this edge.
- `audio_in_L`, `audio_in_R` in DATA_W: input sample.
- `audio_out_allowed` in 1: codec can accept an output sample.
- `write_audio_out` out 1: output sample transferred at this edge.
- `audio_out_L`, `audio_out_R` out DATA_W: FIFO head sample.
- `gain` in GAIN_W: target gain.
- `mute` in 1: target gain becomes 0.
- `bypass` in 1: output = input; same latency.
- `clip_clear` in 1: clears clip flags.
- `clip_L`, `clip_R` out 1: sticky saturation flags.
- `fifo_level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Credit: `read_audio_in = !reset && audio_in_available && (fifo_level + in_flight < DEPTH)`. `in_flight` counts valid stages S1 and S2 (0..2).
- S1 edge: register L/R, the current gain `cur_gain` and `bypass`.
- Ramp: on each accepted sample, `cur_gain` moves RAMP_STEP toward target (`mute ? 0 : gain`) and clamps at the target with no overshoot. The sample uses the pre-update value. Between accepted samples, `cur_gain` holds.
- S2 edge: multiply as signed, `in * $signed({1'b0,cur_gain})`, full width DATA_W+GAIN_W+1.
  - Arithmetic shift right by GAIN_W-2, which floors.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. A clip on a channel sets that channel's flag.
  - If `bypass` was captured, S2 = input unchanged and no clip is possible.
- Clip flags: `clip_clear` clears them; a set on the same edge wins.
- FIFO: S2 valid pushes at the next edge.
  - `write_audio_out = !reset && audio_out_allowed && fifo_level != 0`. Pop on that edge.
  - `audio_out_*` show the head combinationally and equal 0 when empty.
  - Push and pop on the same edge leave the level unchanged. Credit rule makes overflow impossible. Order is strictly preserved.
- Reset (any time, including mid-stream): flush S1/S2 and the FIFO, drop in-flight samples.
  - Reset values: `read_audio_in` = 0, `write_audio_out` = 0, `audio_out_*` = 0, `fifo_level` = 0, `clip_*` = 0, `cur_gain` = unity.

## Timing
- Sample accepted at edge k: in S1 after k, in S2 after k+1, in the FIFO after k+2.
- Earliest `write_audio_out` is in the cycle after k+2, with the transfer at edge k+3. Latency is 3 cycles, identical in bypass.
- Data is valid throughout any cycle with `write_audio_out` = 1; there is no write-before-data.
- Sustained throughput is 1 sample/cycle when `audio_out_allowed` is held high.
- Gain, mute and bypass changes affect only samples accepted after the change.

## Structure
- Package `audio_pkg` holds:
  - `sample_t` struct {L, R} parameterised via DATA_W default.
  - `UNITY_GAIN` localparam derivation.
  - `sat_shift()` function (shift plus saturate, returns value and clip).
- Sub-module `audio_sample_fifo`: register-array FIFO, show-ahead, with `push`, `pop`, `level`, `empty` and `full`, synchronous active-high `reset`.
- Top: credit logic, ramp, S1/S2 pipeline, clip flags.

## Test plan
1. Reset; gain=64; input 1000/-1000; both flags high → output 1000/-1000. First `write_audio_out` is 3 edges after the first read, with data valid in that cycle.
2. gain=128; input 32'h70000000 / -32'h70000000 → output 32'h7FFFFFFF / 32'h80000000, `clip_L`=`clip_R`=1. `clip_clear` → both flags 0.
3. RAMP_STEP=16; `cur_gain`=64; mute=1; stream constant 6400 → outputs 6400, 4800, 3200, 1600, 0, then 0 sustained. Unmute → 0, 1600, 3200, 4800, 6400.
4. `audio_out_allowed`=0; DEPTH=4; stream 6 distinct samples → exactly 4 accepted, `read_audio_in` low once level+in_flight=4. Allow output → the 4 samples emerge in order, then the remaining 2, with no loss or duplicates.
5. bypass=1, gain=0, input 32'hDEADBEEF → output 32'hDEADBEEF after 3 cycles, clip flags 0.
6. Assert reset with 3 samples queued → on the next cycle `fifo_level`=0, `write_audio_out`=0, `audio_out_*`=0. After release, the first new sample uses unity gain.
